// File: rtl/laser_pkg.sv
// Shared definitions for the laser shot receive path: FSM encodings, the no-return
// marker and the packed layout of the per-shot flag word.
package laser_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Wide all-ones pattern; users truncate to their own time-word width.
    localparam logic [63:0] NO_ECHO_TOF = '1;

    // Bit 2 = overflow, bit 1 = timeout, bit 0 = no_fire.
    typedef struct packed {
        logic overflow;
        logic timeout;
        logic no_fire;
    } shot_flags_t;

endpackage

// File: rtl/echo_pair_detect.sv
// Pairs TDC rise/fall stop events into echoes; strobes {tof, width} in the cycle of
// the qualifying falling edge.
module echo_pair_detect #(
    parameter int TW        = 16,
    parameter int MIN_WIDTH = 2
) (
    input  logic          i_clk_50m,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_hit_en,
    input  logic          i_hit_edge,
    input  logic [TW-1:0] i_hit_time,
    output logic          o_echo_stb,
    output logic [TW-1:0] o_echo_tof,
    output logic [TW-1:0] o_echo_width
);

    logic          pend_q, pend_d;
    logic [TW-1:0] rise_q, rise_d;
    logic [TW-1:0] width;

    always_comb begin
        pend_d     = pend_q;
        rise_d     = rise_q;
        width      = i_hit_time - rise_q;
        o_echo_stb = 1'b0;
        if (i_clear) begin
            pend_d = 1'b0;
        end else if (i_hit_en) begin
            if (i_hit_edge) begin
                pend_d = 1'b1;
                rise_d = i_hit_time;
            end else if (pend_q) begin
                pend_d     = 1'b0;
                o_echo_stb = (width >= TW'(MIN_WIDTH));
            end
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= 1'b0;
            rise_q <= '0;
        end else begin
            pend_q <= pend_d;
            rise_q <= rise_d;
        end
    end

    assign o_echo_tof   = rise_q;
    assign o_echo_width = width;

endmodule

// File: rtl/tdc_echo_capture.sv
// Collects TDC echoes while the window is open, buffers up to MAX_ECHO per shot and
// streams them out over valid/ready with per-shot flags.
//  state   | meaning
//  IDLE    | waiting for the TDC window to open (i_disable_tdc 1->0)
//  COLLECT | window open, pairing and buffering echoes, counting window cycles
//  OUTPUT  | streaming buffered echoes (or one no-return word)
//  DONE    | one-cycle shot_done pulse
module tdc_echo_capture
    import laser_pkg::*;
#(
    parameter int TW        = 16,
    parameter int MAX_ECHO  = 4,
    parameter int MIN_WIDTH = 2,
    parameter int TIMEOUT   = 255,
    localparam int IW       = $clog2(MAX_ECHO)
) (
    input  logic          i_clk_50m,
    input  logic          i_rst_n,
    input  logic          i_disable_tdc,
    input  logic          i_laser_str,
    input  logic          i_hit_valid,
    input  logic          i_hit_edge,
    input  logic [TW-1:0] i_hit_time,
    output logic          o_echo_valid,
    input  logic          i_echo_ready,
    output logic [TW-1:0] o_echo_tof,
    output logic [TW-1:0] o_echo_width,
    output logic [IW-1:0] o_echo_idx,
    output logic          o_echo_last,
    output logic [2:0]    o_shot_flags,
    output logic          o_shot_done
);

    localparam int CW    = IW + 1;
    localparam int WIN_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] NO_TOF = TW'(NO_ECHO_TOF);

    logic [1:0]       state_q, state_d;
    logic             dis_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             ovf_q, ovf_d, tmo_q, tmo_d, fired_q, fired_d;
    logic [TW-1:0]    buf_tof_q [MAX_ECHO];
    logic [TW-1:0]    buf_tof_d [MAX_ECHO];
    logic [TW-1:0]    buf_w_q   [MAX_ECHO];
    logic [TW-1:0]    buf_w_d   [MAX_ECHO];

    logic             collecting, win_expired, hit_en;
    logic             echo_stb;
    logic [TW-1:0]    echo_tof, echo_width;
    logic [IW-1:0]    last_idx;
    logic             in_output, is_last;
    shot_flags_t      flags;

    assign collecting  = (state_q == ST_COLLECT);
    assign win_expired = (win_q == WIN_W'(TIMEOUT));
    // Hits in the closing cycle (gate raised or timeout reached) are dropped.
    assign hit_en      = collecting && i_hit_valid && !i_disable_tdc && !win_expired;

    echo_pair_detect #(.TW(TW), .MIN_WIDTH(MIN_WIDTH)) u_pair (
        .i_clk_50m    (i_clk_50m),
        .i_rst_n      (i_rst_n),
        .i_clear      (!collecting),
        .i_hit_en     (hit_en),
        .i_hit_edge   (i_hit_edge),
        .i_hit_time   (i_hit_time),
        .o_echo_stb   (echo_stb),
        .o_echo_tof   (echo_tof),
        .o_echo_width (echo_width)
    );

    assign last_idx = (cnt_q == '0) ? '0 : IW'(cnt_q - CW'(1));
    assign is_last  = (rd_idx_q == last_idx);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        win_d     = win_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        fired_d   = fired_q;
        buf_tof_d = buf_tof_q;
        buf_w_d   = buf_w_q;
        case (state_q)
            ST_IDLE: begin
                if (dis_prev_q && !i_disable_tdc) begin
                    state_d  = ST_COLLECT;
                    cnt_d    = '0;
                    rd_idx_d = '0;
                    win_d    = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b0;
                    fired_d  = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (i_laser_str) fired_d = 1'b1;
                if (win_q != '1) win_d = win_q + WIN_W'(1);
                if (echo_stb) begin
                    if (cnt_q < CW'(MAX_ECHO)) begin
                        buf_tof_d[cnt_q[IW-1:0]] = echo_tof;
                        buf_w_d[cnt_q[IW-1:0]]   = echo_width;
                        cnt_d                    = cnt_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (i_disable_tdc || win_expired) begin
                    state_d  = ST_OUTPUT;
                    rd_idx_d = '0;
                    if (win_expired) tmo_d = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (i_echo_ready) begin
                    if (is_last) state_d = ST_DONE;
                    else         rd_idx_d = rd_idx_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            dis_prev_q <= 1'b1;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            win_q      <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            fired_q    <= 1'b0;
            for (int i = 0; i < MAX_ECHO; i++) begin
                buf_tof_q[i] <= '0;
                buf_w_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            dis_prev_q <= i_disable_tdc;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            win_q      <= win_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            fired_q    <= fired_d;
            buf_tof_q  <= buf_tof_d;
            buf_w_q    <= buf_w_d;
        end
    end

    assign in_output     = (state_q == ST_OUTPUT);
    assign flags.overflow = ovf_q;
    assign flags.timeout  = tmo_q;
    assign flags.no_fire  = !fired_q;

    assign o_echo_valid = in_output;
    assign o_echo_tof   = !in_output ? '0 : (cnt_q == '0) ? NO_TOF : buf_tof_q[rd_idx_q];
    assign o_echo_width = (!in_output || cnt_q == '0) ? '0 : buf_w_q[rd_idx_q];
    assign o_echo_idx   = in_output ? rd_idx_q : '0;
    assign o_echo_last  = in_output && is_last;
    assign o_shot_flags = in_output ? flags : 3'b000;
    assign o_shot_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_tdc_echo_capture.sv
// Directed bench for tdc_echo_capture: per-shot hit lists feed a pairing model that
// predicts the echo stream; a negedge compare process checks every output word.
module tb_tdc_echo_capture;

    localparam int TW   = 16;
    localparam int ME   = 4;
    localparam int MINW = 2;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dis_tdc, laser_str, hit_valid, hit_edge;
    logic [TW-1:0] hit_time;
    logic          echo_valid, echo_ready, echo_last, shot_done;
    logic [TW-1:0] echo_tof, echo_width;
    logic [1:0]    echo_idx;
    logic [2:0]    shot_flags;

    always #10 clk = ~clk;

    tdc_echo_capture #(.TW(TW), .MAX_ECHO(ME), .MIN_WIDTH(MINW), .TIMEOUT(TMO)) dut (
        .i_clk_50m     (clk),
        .i_rst_n       (rst_n),
        .i_disable_tdc (dis_tdc),
        .i_laser_str   (laser_str),
        .i_hit_valid   (hit_valid),
        .i_hit_edge    (hit_edge),
        .i_hit_time    (hit_time),
        .o_echo_valid  (echo_valid),
        .i_echo_ready  (echo_ready),
        .o_echo_tof    (echo_tof),
        .o_echo_width  (echo_width),
        .o_echo_idx    (echo_idx),
        .o_echo_last   (echo_last),
        .o_shot_flags  (shot_flags),
        .o_shot_done   (shot_done)
    );

    typedef struct {
        int          cyc;
        bit          rise;
        logic [15:0] t;
    } hit_t;

    typedef struct {
        logic [15:0] tof;
        logic [15:0] width;
        logic [1:0]  idx;
        logic        last;
        logic [2:0]  flags;
    } word_t;

    hit_t  hits[$];
    word_t exp_q[$];
    word_t got_q[$];
    int    cmp_cnt = 0;
    int    err_cnt = 0;
    int    done_cnt = 0;
    bit    chk_en = 0;
    int    ready_mode = 0;
    bit    hold = 0;
    bit    done_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Spec-level prediction: hits accepted strictly before the close cycle and before
    // the timeout cycle; pair rise->fall, drop narrow echoes, cap at ME.
    function automatic void model(input int close_cyc, input int fire_cyc);
        logic [15:0] rise_t = '0;
        logic [15:0] wd;
        bit          pend = 0;
        bit          ovf = 0;
        bit          fired;
        int          n = 0;
        word_t       w;
        word_t       tmp[$];
        logic [2:0]  fl;
        foreach (hits[i]) begin
            if (hits[i].cyc >= close_cyc || hits[i].cyc >= TMO) continue;
            if (hits[i].rise) begin
                pend   = 1;
                rise_t = hits[i].t;
            end else if (pend) begin
                pend = 0;
                wd   = hits[i].t - rise_t;
                if (wd >= MINW) begin
                    if (n < ME) begin
                        w.tof = rise_t; w.width = wd;
                        tmp.push_back(w);
                        n++;
                    end else ovf = 1;
                end
            end
        end
        fired = (fire_cyc >= 0) && (fire_cyc <= close_cyc) && (fire_cyc <= TMO);
        fl    = {ovf, (close_cyc > TMO), !fired};
        if (n == 0) begin
            w.tof = 16'hFFFF; w.width = 0; w.idx = 0; w.last = 1; w.flags = fl;
            exp_q.push_back(w);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = tmp[i];
                w.idx = 2'(i); w.last = (i == n - 1); w.flags = fl;
                exp_q.push_back(w);
            end
        end
    endfunction

    always @(negedge clk) begin
        word_t e, a;
        if (!chk_en) begin
            hold     = 0;
            done_exp = 0;
        end else begin
            check("shot_done", shot_done, done_exp);
            if (shot_done) done_cnt++;
            done_exp = 0;
            if (hold) check("valid_hold", echo_valid, 1);
            if (echo_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", echo_valid, 0);
                end else begin
                    e = exp_q[0];
                    a.tof = echo_tof; a.width = echo_width; a.idx = echo_idx;
                    a.last = echo_last; a.flags = shot_flags;
                    check("tof", a.tof, e.tof);
                    check("width", a.width, e.width);
                    check("idx", a.idx, e.idx);
                    check("last", a.last, e.last);
                    check("flags", a.flags, e.flags);
                    if (echo_ready) begin
                        got_q.push_back(a);
                        done_exp = e.last;
                        void'(exp_q.pop_front());
                    end
                end
            end
            hold = echo_valid && !echo_ready;
        end
    end

    initial begin
        echo_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       echo_ready = 1'b1;
                1:       echo_ready = 1'($urandom_range(0, 1));
                default: echo_ready = 1'b0;
            endcase
        end
    end

    task automatic add_hit(input int cyc, input bit rise, input logic [15:0] t);
        hit_t h;
        h.cyc = cyc; h.rise = rise; h.t = t;
        hits.push_back(h);
    endtask

    task automatic run_shot(input int close_cyc, input int fire_cyc, input bit wait_done);
        int last_c = close_cyc;
        int target = done_cnt + 1;
        foreach (hits[i]) if (hits[i].cyc > last_c) last_c = hits[i].cyc;
        model(close_cyc, fire_cyc);
        got_q.delete();
        @(posedge clk); #1;
        dis_tdc = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            dis_tdc   = (c >= close_cyc);
            laser_str = (c == fire_cyc);
            hit_valid = 1'b0;
            foreach (hits[i]) if (hits[i].cyc == c) begin
                hit_valid = 1'b1;
                hit_edge  = hits[i].rise;
                hit_time  = hits[i].t;
            end
        end
        @(posedge clk); #1;
        hit_valid = 1'b0; laser_str = 1'b0; dis_tdc = 1'b1;
        if (wait_done) begin
            for (int k = 0; k < 200 && done_cnt < target; k++) @(posedge clk);
            if (done_cnt < target) check("shot_done_wait", done_cnt, target);
            repeat (3) @(posedge clk);
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    task automatic shot1_hits();
        hits.delete();
        add_hit(0, 1, 100); add_hit(1, 0, 140);
        add_hit(2, 1, 300); add_hit(3, 0, 301);
        add_hit(5, 1, 500);
    endtask

    initial begin
        rst_n = 1'b0; dis_tdc = 1'b1; laser_str = 1'b0;
        hit_valid = 1'b0; hit_edge = 1'b0; hit_time = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", echo_valid, 0);
        check("rst_tof", echo_tof, 0);
        check("rst_width", echo_width, 0);
        check("rst_idx", echo_idx, 0);
        check("rst_last", echo_last, 0);
        check("rst_flags", shot_flags, 0);
        check("rst_done", shot_done, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1;
        repeat (2) @(posedge clk);

        // Narrow second echo dropped; rise in the close cycle dropped.
        shot1_hits();
        run_shot(5, 0, 1);
        check("t1_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("t1_tof", got_q[0].tof, 16'd100);
            check("t1_width", got_q[0].width, 16'd40);
        end

        // Five width-10 pairs into a four-deep buffer.
        hits.delete();
        for (int k = 0; k < 5; k++) begin
            add_hit(2 * k, 1, 16'(1000 + 20 * k));
            add_hit(2 * k + 1, 0, 16'(1010 + 20 * k));
        end
        run_shot(11, 0, 1);
        check("t2_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t2_idx3", got_q[3].idx, 3);
            check("t2_last3", got_q[3].last, 1);
            check("t2_flags", got_q[3].flags, 3'b100);
        end

        // Empty window, no laser strobe.
        hits.delete();
        run_shot(2, -1, 1);
        if (got_q.size() > 0) begin
            check("t3_tof", got_q[0].tof, 16'hFFFF);
            check("t3_flags", got_q[0].flags, 3'b001);
        end

        // Wrap, rise replacement, orphan fall, fall in close cycle.
        hits.delete();
        add_hit(0, 1, 16'hFFF0); add_hit(1, 0, 16'h0010);
        add_hit(2, 1, 40); add_hit(3, 1, 50); add_hit(4, 0, 60);
        add_hit(5, 0, 65); add_hit(6, 1, 70); add_hit(7, 0, 90);
        run_shot(7, 0, 1);
        check("t4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t4_wrap_width", got_q[0].width, 16'h0020);
            check("t4_tof", got_q[1].tof, 16'd50);
            check("t4_width", got_q[1].width, 16'd10);
        end

        // Window held open past the timeout.
        hits.delete();
        add_hit(0, 1, 10); add_hit(1, 0, 30);
        add_hit(260, 1, 500); add_hit(261, 0, 520);
        add_hit(300, 0, 600);
        run_shot(300, 0, 1);
        if (got_q.size() > 0) begin
            check("t5_flags", got_q[0].flags, 3'b010);
            check("t5_width", got_q[0].width, 16'd20);
        end

        // Random backpressure.
        ready_mode = 1;
        hits.delete();
        for (int k = 0; k < 4; k++) begin
            add_hit(2 * k, 1, 16'(2000 + 7 * k));
            add_hit(2 * k + 1, 0, 16'(2003 + 7 * k + k));
        end
        run_shot(9, 3, 1);
        check("t6_count", got_q.size(), 4);

        // Reset in the middle of the output stream.
        ready_mode = 2;
        run_shot(9, 3, 0);
        for (int k = 0; k < 20 && !echo_valid; k++) @(posedge clk);
        check("t7_valid_seen", echo_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("t7_rst_valid", echo_valid, 0);
        check("t7_rst_tof", echo_tof, 0);
        check("t7_rst_flags", shot_flags, 0);
        check("t7_rst_last", echo_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        ready_mode = 0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        shot1_hits();
        run_shot(5, 0, 1);
        check("t7_after_count", got_q.size(), 1);
        if (got_q.size() > 0) check("t7_after_tof", got_q[0].tof, 16'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
